// File: rtl/bus_pkg.sv
// Shared bus definitions for the memory_wrapped slave.
// Holds the transfer-size encoding, the transfer-type encoding, the region
// nibble decoded by the interconnect, and the byte-lane steering helpers
// used by the slave.
package bus_pkg;

    typedef enum logic [1:0] {
        TSIZE_BYTE = 2'b00,
        TSIZE_HALF = 2'b01,
        TSIZE_WORD = 2'b10
    } tsize_e;

    localparam logic TTYPE_READ  = 1'b0;
    localparam logic TTYPE_WRITE = 1'b1;

    // Address nibble addr[31:28] that selects this slave.
    localparam logic [3:0] REGION_NIBBLE = 4'hF;

    // Byte enables for a store. Misaligned halves/words are aligned down by
    // ignoring the low offset bits. tsize 2'b11 falls into the word case.
    function automatic logic [3:0] lane_be(input logic [1:0] tsize,
                                           input logic [1:0] off);
        case (tsize)
            TSIZE_BYTE: lane_be = 4'b0001 << off;
            TSIZE_HALF: lane_be = off[1] ? 4'b1100 : 4'b0011;
            default:    lane_be = 4'b1111;
        endcase
    endfunction

    // Replicate right-aligned write data into every lane it could target;
    // the byte enables pick the lanes that actually get written.
    function automatic logic [31:0] lane_wdata(input logic [1:0]  tsize,
                                               input logic [31:0] wdata);
        case (tsize)
            TSIZE_BYTE: lane_wdata = {4{wdata[7:0]}};
            TSIZE_HALF: lane_wdata = {2{wdata[15:0]}};
            default:    lane_wdata = wdata;
        endcase
    endfunction

    // Shift the addressed lanes of a stored word down to bit 0, zero-extended.
    function automatic logic [31:0] read_align(input logic [31:0] word,
                                               input logic [1:0]  tsize,
                                               input logic [1:0]  off);
        logic [31:0] sh;
        case (tsize)
            TSIZE_BYTE: begin
                sh         = word >> {off, 3'b000};
                read_align = {24'h0, sh[7:0]};
            end
            TSIZE_HALF: begin
                sh         = word >> {off[1], 4'b0000};
                read_align = {16'h0, sh[15:0]};
            end
            default: read_align = word;
        endcase
    endfunction

endpackage

// File: rtl/slave_bus_if.sv
// Simple strobe/done slave bus.
// Signals: ss (slave select), bstart (one-cycle start strobe), addr (byte
// address), tsize (byte/half/word), ttype (1 = write), wdata (right-aligned
// write data), rdata (read data), bdone (one-cycle completion pulse).
//
// Handshake: a transfer is accepted on a rising edge where ss && bstart.
// There is no back-pressure; the slave always accepts. bdone pulses for
// exactly one cycle per accepted transfer, and rdata is meaningful only while
// bdone is high (it reads as zero otherwise, and for writes).
interface slave_bus_if;
    logic        ss;
    logic        bstart;
    logic [31:0] addr;
    logic [1:0]  tsize;
    logic        ttype;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        bdone;

    modport slave (
        input  ss, bstart, addr, tsize, ttype, wdata,
        output rdata, bdone
    );

    modport master (
        output ss, bstart, addr, tsize, ttype, wdata,
        input  rdata, bdone
    );
endinterface

// File: rtl/dp_ram.sv
// Word-wide storage with one read port and one read/write port.
// Ports:
//   clk        - write clock
//   ra_addr_i  - read-only port word index
//   ra_rdata_o - read-only port data (combinational)
//   rw_addr_i  - read/write port word index
//   rw_we_i    - write enable for the read/write port
//   rw_be_i    - per-byte write enables
//   rw_wdata_i - write data, already placed in its lanes
//   rw_rdata_o - read/write port read data (combinational, pre-write value)
// The array has no reset so it can be preloaded hierarchically via mem.
module dp_ram #(
    parameter  int DEPTH = 1024,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic [AW-1:0] ra_addr_i,
    output logic [31:0]   ra_rdata_o,
    input  logic [AW-1:0] rw_addr_i,
    input  logic          rw_we_i,
    input  logic [3:0]    rw_be_i,
    input  logic [31:0]   rw_wdata_i,
    output logic [31:0]   rw_rdata_o
);

    logic [31:0] mem [0:DEPTH-1];

    assign ra_rdata_o = mem[ra_addr_i];
    assign rw_rdata_o = mem[rw_addr_i];

    always_ff @(posedge clk) begin
        if (rw_we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (rw_be_i[b]) begin
                    mem[rw_addr_i][8*b +: 8] <= rw_wdata_i[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/memory_wrapped.sv
// Dual-port on-chip memory slave: read-only instruction port (ibus) and
// read/write data port (dbus), both on slave_bus_if.
// Ports:
//   clk   - sole clock
//   rst_n - asynchronous active-low reset (clears bdone/rdata, not memory)
//   ibus  - instruction port; ttype and wdata are ignored
//   dbus  - data port; byte/half/word reads and byte-enabled writes
//
// Pipeline per port: the accepting edge captures the request; during the
// following cycle the array is read (and for dbus writes, written at the
// next edge), and that edge also raises bdone with the steered rdata. Since
// the array reads are combinational off the captured index, an ibus read
// captured together with a dbus write to the same word sees the old value,
// and a request captured right after a write sees the new one.
// DEPTH is expected to be a power of two so index truncation wraps.
module memory_wrapped
    import bus_pkg::*;
#(
    parameter int DEPTH    = 1024,
    parameter int ADDR_LSB = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    slave_bus_if.slave ibus,
    slave_bus_if.slave dbus
);

    localparam int AW = $clog2(DEPTH);

    // Captured requests.
    logic          i_pend_q, i_pend_d;
    logic [AW-1:0] i_idx_q, i_idx_d;
    logic [1:0]    i_off_q, i_off_d;
    logic [1:0]    i_size_q, i_size_d;

    logic          d_pend_q, d_pend_d;
    logic [AW-1:0] d_idx_q, d_idx_d;
    logic [1:0]    d_off_q, d_off_d;
    logic [1:0]    d_size_q, d_size_d;
    logic          d_wr_q, d_wr_d;
    logic [31:0]   d_wdata_q, d_wdata_d;

    // Completion registers.
    logic          i_done_q, i_done_d;
    logic [31:0]   i_rdata_q, i_rdata_d;
    logic          d_done_q, d_done_d;
    logic [31:0]   d_rdata_q, d_rdata_d;

    logic [31:0]   ram_i_rdata;
    logic [31:0]   ram_d_rdata;
    logic          ram_we;
    logic [3:0]    ram_be;
    logic [31:0]   ram_wdata;

    always_comb begin
        i_pend_d  = ibus.ss & ibus.bstart;
        i_idx_d   = i_idx_q;
        i_off_d   = i_off_q;
        i_size_d  = i_size_q;
        d_pend_d  = dbus.ss & dbus.bstart;
        d_idx_d   = d_idx_q;
        d_off_d   = d_off_q;
        d_size_d  = d_size_q;
        d_wr_d    = d_wr_q;
        d_wdata_d = d_wdata_q;

        if (i_pend_d) begin
            i_idx_d  = ibus.addr[ADDR_LSB +: AW];
            i_off_d  = ibus.addr[1:0];
            i_size_d = ibus.tsize;
        end
        if (d_pend_d) begin
            d_idx_d   = dbus.addr[ADDR_LSB +: AW];
            d_off_d   = dbus.addr[1:0];
            d_size_d  = dbus.tsize;
            d_wr_d    = (dbus.ttype == TTYPE_WRITE);
            d_wdata_d = dbus.wdata;
        end

        i_done_d  = i_pend_q;
        i_rdata_d = i_pend_q ? read_align(ram_i_rdata, i_size_q, i_off_q) : 32'h0;
        d_done_d  = d_pend_q;
        d_rdata_d = (d_pend_q && !d_wr_q) ?
                    read_align(ram_d_rdata, d_size_q, d_off_q) : 32'h0;
    end

    // Reset drops any captured request, so a pending write never lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_pend_q  <= 1'b0;
            i_idx_q   <= '0;
            i_off_q   <= '0;
            i_size_q  <= '0;
            d_pend_q  <= 1'b0;
            d_idx_q   <= '0;
            d_off_q   <= '0;
            d_size_q  <= '0;
            d_wr_q    <= 1'b0;
            d_wdata_q <= '0;
            i_done_q  <= 1'b0;
            i_rdata_q <= '0;
            d_done_q  <= 1'b0;
            d_rdata_q <= '0;
        end else begin
            i_pend_q  <= i_pend_d;
            i_idx_q   <= i_idx_d;
            i_off_q   <= i_off_d;
            i_size_q  <= i_size_d;
            d_pend_q  <= d_pend_d;
            d_idx_q   <= d_idx_d;
            d_off_q   <= d_off_d;
            d_size_q  <= d_size_d;
            d_wr_q    <= d_wr_d;
            d_wdata_q <= d_wdata_d;
            i_done_q  <= i_done_d;
            i_rdata_q <= i_rdata_d;
            d_done_q  <= d_done_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    assign ram_we    = d_pend_q & d_wr_q;
    assign ram_be    = lane_be(d_size_q, d_off_q);
    assign ram_wdata = lane_wdata(d_size_q, d_wdata_q);

    dp_ram #(.DEPTH(DEPTH)) wrapped_mem (
        .clk        (clk),
        .ra_addr_i  (i_idx_q),
        .ra_rdata_o (ram_i_rdata),
        .rw_addr_i  (d_idx_q),
        .rw_we_i    (ram_we),
        .rw_be_i    (ram_be),
        .rw_wdata_i (ram_wdata),
        .rw_rdata_o (ram_d_rdata)
    );

    assign ibus.bdone = i_done_q;
    assign ibus.rdata = i_rdata_q;
    assign dbus.bdone = d_done_q;
    assign dbus.rdata = d_rdata_q;

    // ibus never writes, and only part of each address selects a word.
    logic unused_bus;
    assign unused_bus = ^{ibus.ttype, ibus.wdata, ibus.addr, dbus.addr};

endmodule

// File: tb/tb_memory_wrapped.sv
module tb_memory_wrapped;
    import bus_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    slave_bus_if ibus_if ();
    slave_bus_if dbus_if ();

    memory_wrapped #(.DEPTH(1024), .ADDR_LSB(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ibus  (ibus_if),
        .dbus  (dbus_if)
    );

    // ---------------- scoreboard ----------------
    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] exp_i_q[$];
    logic [31:0] exp_d_q[$];
    int          cyc_i_q[$];
    int          cyc_d_q[$];
    logic [31:0] model [0:1023];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        logic [31:0] e;
        int          c;
        while (cyc_i_q.size() > 0 && cyc_i_q[0] < cyc) begin
            n_cmp++; n_fail++;
            $display("FAIL ibus_missing_bdone: got none, required bdone at cycle %0d", cyc_i_q[0]);
            void'(cyc_i_q.pop_front()); void'(exp_i_q.pop_front());
        end
        if (ibus_if.bdone === 1'b1) begin
            n_cmp++;
            if (exp_i_q.size() == 0) begin
                n_fail++;
                $display("FAIL ibus_spurious_bdone: got bdone at cycle %0d, required none", cyc);
            end else begin
                e = exp_i_q.pop_front(); c = cyc_i_q.pop_front();
                if (ibus_if.rdata !== e || c != cyc) begin
                    n_fail++;
                    $display("FAIL ibus_rdata: got %h at cycle %0d, required %h at cycle %0d",
                             ibus_if.rdata, cyc, e, c);
                end
            end
        end else if (ibus_if.rdata !== 32'h0) begin
            n_cmp++; n_fail++;
            $display("FAIL ibus_idle_rdata: got %h, required 00000000", ibus_if.rdata);
        end

        while (cyc_d_q.size() > 0 && cyc_d_q[0] < cyc) begin
            n_cmp++; n_fail++;
            $display("FAIL dbus_missing_bdone: got none, required bdone at cycle %0d", cyc_d_q[0]);
            void'(cyc_d_q.pop_front()); void'(exp_d_q.pop_front());
        end
        if (dbus_if.bdone === 1'b1) begin
            n_cmp++;
            if (exp_d_q.size() == 0) begin
                n_fail++;
                $display("FAIL dbus_spurious_bdone: got bdone at cycle %0d, required none", cyc);
            end else begin
                e = exp_d_q.pop_front(); c = cyc_d_q.pop_front();
                if (dbus_if.rdata !== e || c != cyc) begin
                    n_fail++;
                    $display("FAIL dbus_rdata: got %h at cycle %0d, required %h at cycle %0d",
                             dbus_if.rdata, cyc, e, c);
                end
            end
        end else if (dbus_if.rdata !== 32'h0) begin
            n_cmp++; n_fail++;
            $display("FAIL dbus_idle_rdata: got %h, required 00000000", dbus_if.rdata);
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] model_read(input logic [31:0] addr, input logic [1:0] sz);
        logic [31:0] w;
        w = model[addr[11:2]];
        case (sz)
            2'b00:   return (w >> (8 * addr[1:0])) & 32'h0000_00FF;
            2'b01:   return (w >> (16 * addr[1])) & 32'h0000_FFFF;
            default: return w;
        endcase
    endfunction

    task automatic model_write(input logic [31:0] addr, input logic [1:0] sz, input logic [31:0] wd);
        logic [31:0] w;
        w = model[addr[11:2]];
        case (sz)
            2'b00:   w[8 * addr[1:0] +: 8] = wd[7:0];
            2'b01:   w[16 * addr[1] +: 16] = wd[15:0];
            default: w = wd;
        endcase
        model[addr[11:2]] = w;
    endtask

    // ---------------- drivers ----------------
    // Called just after a rising edge; the request is accepted at the next
    // edge and completes (bdone) at the edge after that.
    task automatic set_i(input logic [31:0] addr, input logic [1:0] sz, input logic tt,
                         input logic [31:0] wd, input logic [31:0] exp);
        ibus_if.ss = 1'b1; ibus_if.bstart = 1'b1; ibus_if.addr = addr;
        ibus_if.tsize = sz; ibus_if.ttype = tt; ibus_if.wdata = wd;
        exp_i_q.push_back(exp); cyc_i_q.push_back(cyc + 2);
    endtask

    task automatic set_d(input logic ss, input logic [31:0] addr, input logic [1:0] sz,
                         input logic wr, input logic [31:0] wd, input logic [31:0] exp);
        dbus_if.ss = ss; dbus_if.bstart = 1'b1; dbus_if.addr = addr;
        dbus_if.tsize = sz; dbus_if.ttype = wr; dbus_if.wdata = wd;
        if (ss) begin
            exp_d_q.push_back(exp); cyc_d_q.push_back(cyc + 2);
            if (wr) model_write(addr, sz, wd);
        end
    endtask

    task automatic idle_inputs();
        ibus_if.ss = 1'b0; ibus_if.bstart = 1'b0; ibus_if.ttype = TTYPE_READ;
        dbus_if.ss = 1'b0; dbus_if.bstart = 1'b0; dbus_if.ttype = TTYPE_READ;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        logic        port_d;
        logic        ss;
        logic        wr;
        logic [31:0] addr;
        logic [1:0]  sz;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [17];

    initial begin
        logic [31:0] a;
        logic [31:0] ie;
        logic [1:0]  isz;
        idle_inputs();
        ibus_if.addr = '0; ibus_if.tsize = '0; ibus_if.wdata = '0;
        dbus_if.addr = '0; dbus_if.tsize = '0; dbus_if.wdata = '0;

        for (int k = 0; k < 8; k++) model[k] = 32'hA5A5_0000 + 32'(k);
        model[0]    = 32'h0050_0093;
        model[4]    = 32'hCAFE_F00D;
        model[8'h41] = 32'h1122_3344;
        for (int k = 0; k < 8; k++) dut.wrapped_mem.mem[k] = model[k];
        dut.wrapped_mem.mem[8'h41] = model[8'h41];

        //          port  ss    wr    addr            sz     wdata           exp
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 32'hF000_0000, 2'b10, 32'h0,          32'h0050_0093};
        vecs[1]  = '{1'b1, 1'b1, 1'b1, 32'hF000_0105, 2'b00, 32'h0000_00AB,  32'h0};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 32'hF000_0104, 2'b10, 32'h0,          32'h1122_AB44};
        vecs[3]  = '{1'b1, 1'b1, 1'b1, 32'hF000_0000, 2'b10, 32'h1234_5678,  32'h0};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 32'hF000_0002, 2'b01, 32'h0,          32'h0000_1234};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 32'hF000_0003, 2'b01, 32'h0,          32'h0000_1234};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 32'hF000_0001, 2'b00, 32'h0,          32'h0000_0056};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 32'hF000_0003, 2'b00, 32'h0,          32'h0000_0012};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 32'hF000_0003, 2'b10, 32'h0,          32'h1234_5678};
        vecs[9]  = '{1'b1, 1'b1, 1'b1, 32'hF000_0107, 2'b01, 32'h0000_BEEF,  32'h0};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 32'hF000_0104, 2'b11, 32'h0,          32'hBEEF_AB44};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 32'hF000_1106, 2'b01, 32'h0,          32'h0000_BEEF};
        vecs[12] = '{1'b1, 1'b0, 1'b1, 32'hF000_0000, 2'b10, 32'hFFFF_FFFF,  32'h0};
        vecs[13] = '{1'b1, 1'b1, 1'b0, 32'hF000_0000, 2'b10, 32'h0,          32'h1234_5678};
        vecs[14] = '{1'b1, 1'b1, 1'b1, 32'hF000_0000, 2'b01, 32'h0000_9999,  32'h0};
        vecs[15] = '{1'b0, 1'b1, 1'b1, 32'hF000_0000, 2'b10, 32'hFFFF_FFFF,  32'h1234_9999};
        vecs[16] = '{1'b1, 1'b1, 1'b0, 32'hF000_0000, 2'b00, 32'h0,          32'h0000_0099};

        // Reset state
        @(negedge clk);
        check("reset_ibus_bdone", {31'h0, ibus_if.bdone}, 32'h0);
        check("reset_ibus_rdata", ibus_if.rdata, 32'h0);
        check("reset_dbus_bdone", {31'h0, dbus_if.bdone}, 32'h0);
        check("reset_dbus_rdata", dbus_if.rdata, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();

        // Table, applied back-to-back
        for (int v = 0; v < 17; v++) begin
            if (vecs[v].port_d)
                set_d(vecs[v].ss, vecs[v].addr, vecs[v].sz, vecs[v].wr, vecs[v].wdata, vecs[v].exp);
            else
                set_i(vecs[v].addr, vecs[v].sz, vecs[v].wr, vecs[v].wdata, vecs[v].exp);
            step();
        end
        repeat (3) step();

        // Same-cycle ibus read and dbus write to one word: old value, then new
        set_i(32'hF000_0010, 2'b10, 1'b0, 32'h0, 32'hCAFE_F00D);
        set_d(1'b1, 32'hF000_0010, 2'b10, 1'b1, 32'hDEAD_BEEF, 32'h0);
        step();
        set_i(32'hF000_0010, 2'b10, 1'b0, 32'h0, 32'hDEAD_BEEF);
        step();
        // Same-cycle reads on both ports
        set_i(32'hF000_0104, 2'b10, 1'b0, 32'h0, 32'hBEEF_AB44);
        set_d(1'b1, 32'hF000_0012, 2'b01, 1'b0, 32'h0, 32'h0000_DEAD);
        step();
        repeat (3) step();

        // Asynchronous clear of a live bdone
        ibus_if.ss = 1'b1; ibus_if.bstart = 1'b1; ibus_if.addr = 32'hF000_0000;
        ibus_if.tsize = 2'b10;
        step();
        @(posedge clk);
        #1;
        check("pre_reset_bdone", {31'h0, ibus_if.bdone}, 32'h1);
        check("pre_reset_rdata", ibus_if.rdata, model_read(32'hF000_0000, 2'b10));
        rst_n = 1'b0;
        #1;
        check("async_clear_bdone", {31'h0, ibus_if.bdone}, 32'h0);
        check("async_clear_rdata", ibus_if.rdata, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();

        // Reset in the cycle after bstart: write dropped, no bdone
        dbus_if.ss = 1'b1; dbus_if.bstart = 1'b1; dbus_if.ttype = TTYPE_WRITE;
        dbus_if.addr = 32'hF000_0000; dbus_if.tsize = 2'b10; dbus_if.wdata = 32'h0BAD_F00D;
        step();
        #1;
        rst_n = 1'b0;
        #1;
        check("drop_bdone", {31'h0, dbus_if.bdone}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        set_i(32'hF000_0000, 2'b10, 1'b0, 32'h0, 32'h1234_9999);
        set_d(1'b1, 32'hF000_0104, 2'b10, 1'b0, 32'h0, 32'hBEEF_AB44);
        step();
        set_i(32'hF000_001C, 2'b10, 1'b0, 32'h0, 32'hA5A5_0007);
        step();
        repeat (3) step();

        // Random mixed traffic against the model
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 2) != 0) begin
                a   = {REGION_NIBBLE, 12'($urandom), 8'h0, 8'($urandom_range(0, 31))};
                isz = 2'($urandom_range(0, 3));
                ie  = model_read(a, isz);
                set_i(a, isz, 1'b0, 32'h0, ie);
            end
            if ($urandom_range(0, 2) != 0) begin
                logic [31:0] da;
                logic [1:0]  dsz;
                logic        dwr;
                logic [31:0] dwd;
                da  = {REGION_NIBBLE, 12'($urandom), 8'h0, 8'($urandom_range(0, 31))};
                dsz = 2'($urandom_range(0, 3));
                dwr = 1'($urandom_range(0, 1));
                dwd = $urandom;
                set_d(($urandom_range(0, 7) != 0), da, dsz, dwr, dwd,
                      dwr ? 32'h0 : model_read(da, dsz));
            end
            step();
        end

        // Drain with a bound
        for (int k = 0; k < 20; k++) begin
            if (exp_i_q.size() == 0 && exp_d_q.size() == 0) break;
            step();
        end
        check("drain_ibus_queue", 32'(exp_i_q.size()), 32'h0);
        check("drain_dbus_queue", 32'(exp_d_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
